// File: rtl/conv_output_writer.sv
// Packs filter output bytes into little-endian 32-bit words, buffers them in a
// small FIFO and writes them to frame memory at incrementing word addresses.
module conv_output_writer #(
  parameter int          IMG_WIDTH  = 64,
  parameter int          IMG_HEIGHT = 64,
  parameter int          ADDR_W     = 12,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              data_write,
  input  logic [7:0]        data_o,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy,
  output logic [1:0]        fsm_state
);
  localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_W     = $clog2(PIX_TOTAL + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [23:0]       pack;
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] push_addr;
  logic              start, take, push, pop, full, drop, wr_en;
  logic [1:0]        lane;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = CAPTURE;
          start     = 1'b1;
        end
      end
      CAPTURE: begin
        if (frame_start) begin
          start = 1'b1;
        end else if (data_write) begin
          take = 1'b1;
          if (pix_cnt == PIX_W'(PIX_TOTAL - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_start) begin
          state_nxt = CAPTURE;
          start     = 1'b1;
        end else if (count == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory handshake: a word transfers on every rising edge where mem_valid and
  // mem_ready are both high; while mem_valid is high and mem_ready low, the
  // address and data are held and mem_valid never drops.
  assign lane  = pix_cnt[1:0];
  assign push  = take && (lane == 2'd3);
  assign pop   = mem_valid && mem_ready;
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign drop  = push && full && !pop;
  assign wr_en = push && !drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      pack      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      push_addr <= BASE_WORD;
      overflow  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (start) begin
        pix_cnt   <= '0;
        pack      <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        push_addr <= BASE_WORD;
        overflow  <= 1'b0;
      end else begin
        if (take) begin
          pix_cnt <= pix_cnt + PIX_W'(1);
          if (!push) pack[{lane, 3'b000} +: 8] <= data_o;
        end
        // Every completed word consumes an address, even when it is dropped.
        if (push) push_addr <= push_addr + ADDR_W'(1);
        if (wr_en) begin
          data_mem[wr_ptr] <= {data_o, pack};
          addr_mem[wr_ptr] <= push_addr;
          wr_ptr           <= wr_ptr + PTR_W'(1);
        end
        if (drop) overflow <= 1'b1;
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (wr_en && !pop) count <= count + CNT_W'(1);
        else if (!wr_en && pop) count <= count - CNT_W'(1);
      end
    end
  end

  assign mem_valid  = (count != '0);
  assign mem_wdata  = data_mem[rd_ptr];
  assign mem_addr   = mem_valid ? addr_mem[rd_ptr] : push_addr;
  assign frame_done = (state == DONE);
  assign busy       = (state == CAPTURE) || (state == DRAIN);
  assign fsm_state  = state;

endmodule

// File: tb/tb_conv_output_writer.sv
// Bench for conv_output_writer: two instances (4x2 frame / depth 4 and
// 4x4 frame / depth 2) share stimulus and are checked against a queue model.
module tb_conv_output_writer;
  localparam int ADDR_W = 12;
  localparam int BASE   = 'h010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, frame_start, data_write, mem_ready;
  logic [7:0] data_o;
  logic [1:0][ADDR_W-1:0] mem_addr;
  logic [1:0][31:0]       mem_wdata;
  logic [1:0]             mem_valid, frame_done, overflow, busy;
  logic [1:0][1:0]        fsm_state;

  always #5 clk = ~clk;

  conv_output_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .ADDR_W(ADDR_W),
                       .BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .data_write(data_write),
    .data_o(data_o), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_valid(mem_valid[0]), .mem_ready(mem_ready), .frame_done(frame_done[0]),
    .overflow(overflow[0]), .busy(busy[0]), .fsm_state(fsm_state[0]));

  conv_output_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .ADDR_W(ADDR_W),
                       .BASE_ADDR(BASE), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .data_write(data_write),
    .data_o(data_o), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_valid(mem_valid[1]), .mem_ready(mem_ready), .frame_done(frame_done[1]),
    .overflow(overflow[1]), .busy(busy[1]), .fsm_state(fsm_state[1]));

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int done_cnt [2] = '{0, 0};
  int stall = 0;
  int d0, d1;
  logic [43:0] q0[$], q1[$];       // model FIFOs: {addr, word}
  logic [43:0] log0[$], log1[$];   // writes accepted by each DUT
  logic [43:0] exp_q[$];           // literal expectations for directed tests
  bit   m_cap [2], m_drn [2], m_done [2], m_ovf [2];
  int   m_nbytes [2], m_next [2];
  logic [31:0] m_word [2];

  function automatic int pix_of(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [43:0] qhead(input int k);
    logic [43:0] e;
    e = '0;
    if (k == 0) begin
      if (q0.size() != 0) e = q0[0];
    end else begin
      if (q1.size() != 0) e = q1[0];
    end
    return e;
  endfunction

  task automatic qpush(input int k, input logic [43:0] e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic model_arm(input int k);
    if (k == 0) q0.delete();
    else q1.delete();
    m_nbytes[k] = 0;
    m_word[k]   = '0;
    m_ovf[k]    = 1'b0;
    m_next[k]   = BASE;
    m_cap[k]    = 1'b1;
    m_drn[k]    = 1'b0;
    m_done[k]   = 1'b0;
  endtask

  task automatic model_reset(input int k);
    model_arm(k);
    m_cap[k] = 1'b0;
  endtask

  // One clock of the frame rules, applied to the inputs seen at the edge.
  task automatic model_step(input int k);
    bit pop;
    pop = (qsize(k) != 0) && mem_ready;
    if (m_done[k]) begin
      m_done[k] = 1'b0;
    end else if (frame_start) begin
      model_arm(k);
    end else if (m_cap[k]) begin
      if (pop) qpop(k);
      if (data_write) begin
        m_word[k] = {data_o, m_word[k][31:8]};
        m_nbytes[k]++;
        if (m_nbytes[k] % 4 == 0) begin
          if (qsize(k) < depth_of(k)) qpush(k, {ADDR_W'(m_next[k]), m_word[k]});
          else m_ovf[k] = 1'b1;
          m_next[k] = (m_next[k] + 1) % (1 << ADDR_W);
        end
        if (m_nbytes[k] == pix_of(k)) begin
          m_cap[k] = 1'b0;
          m_drn[k] = 1'b1;
        end
      end
    end else if (m_drn[k]) begin
      if (qsize(k) == 0) begin
        m_drn[k]  = 1'b0;
        m_done[k] = 1'b1;
      end else if (pop) begin
        qpop(k);
      end
    end
  endtask

  task automatic check(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      if (mem_valid[0] && mem_ready) log0.push_back({mem_addr[0], mem_wdata[0]});
      if (mem_valid[1] && mem_ready) log1.push_back({mem_addr[1], mem_wdata[1]});
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [43:0] h;
      h = qhead(k);
      check("mem_valid", k, 64'(mem_valid[k]), 64'(qsize(k) != 0));
      if (qsize(k) != 0) begin
        check("mem_addr", k, 64'(mem_addr[k]), 64'(h[43:32]));
        check("mem_wdata", k, 64'(mem_wdata[k]), 64'(h[31:0]));
      end
      check("frame_done", k, 64'(frame_done[k]), 64'(m_done[k]));
      check("busy", k, 64'(busy[k]), 64'(m_cap[k] | m_drn[k]));
      check("overflow", k, 64'(overflow[k]), 64'(m_ovf[k]));
      if (frame_done[k]) done_cnt[k]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    data_write = 1'b1;
    data_o     = b;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    log0.delete();
    log1.delete();
  endtask

  task automatic check_log(input int k, input string name);
    logic [43:0] got[$];
    if (k == 0) got = log0;
    else got = log1;
    check({name, "_count"}, k, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check(name, k, 64'(got[i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_valid"}, k, 64'(mem_valid[k]), 64'd0);
      check({tag, "_addr"}, k, 64'(mem_addr[k]), 64'(BASE));
      check({tag, "_wdata"}, k, 64'(mem_wdata[k]), 64'd0);
      check({tag, "_done"}, k, 64'(frame_done[k]), 64'd0);
      check({tag, "_overflow"}, k, 64'(overflow[k]), 64'd0);
      check({tag, "_busy"}, k, 64'(busy[k]), 64'd0);
      check({tag, "_state_idle"}, k, 64'(fsm_state[k]), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset(0);
    model_reset(1);
    rst = 1'b1; frame_start = 1'b0; data_write = 1'b0; data_o = '0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic frame on the 4x2 instance, plus end-of-frame latency.
    start_frame();
    d0 = done_cnt[0];
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("t1_lat1", 0, 64'(frame_done[0]), 64'd0);
    @(negedge clk);
    check("t1_lat2", 0, 64'(frame_done[0]), 64'd0);
    @(negedge clk);
    check("t1_lat3", 0, 64'(frame_done[0]), 64'd1);
    repeat (4) @(negedge clk);
    exp_q.push_back({12'h010, 32'h04030201});
    exp_q.push_back({12'h011, 32'h08070605});
    check_log(0, "t1_write");
    check("t1_done_count", 0, 64'(done_cnt[0] - d0), 64'd1);
    check("t1_overflow", 0, 64'(overflow[0]), 64'd0);

    // Backpressure: output held stable for 20 cycles.
    mem_ready = 1'b0;
    start_frame();
    d0 = done_cnt[0];
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    for (int i = 0; i < 20; i++) begin
      check("t2_hold_valid", 0, 64'(mem_valid[0]), 64'd1);
      check("t2_hold_addr", 0, 64'(mem_addr[0]), 64'h010);
      check("t2_hold_wdata", 0, 64'(mem_wdata[0]), 64'h04030201);
      if (i < 4) send_byte(8'(5 + i));
      else @(negedge clk);
    end
    check("t2_no_early_done", 0, 64'(done_cnt[0] - d0), 64'd0);
    mem_ready = 1'b1;
    repeat (8) @(negedge clk);
    exp_q.push_back({12'h010, 32'h04030201});
    exp_q.push_back({12'h011, 32'h08070605});
    check_log(0, "t2_write");
    check("t2_done_count", 0, 64'(done_cnt[0] - d0), 64'd1);

    // Overflow on the depth-2 instance.
    mem_ready = 1'b0;
    start_frame();
    d1 = done_cnt[1];
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
    check("t3_overflow_set", 1, 64'(overflow[1]), 64'd1);
    check("t3_valid", 1, 64'(mem_valid[1]), 64'd1);
    mem_ready = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back({12'h010, 32'h23222120});
    exp_q.push_back({12'h011, 32'h27262524});
    check_log(1, "t3_write");
    check("t3_done_count", 1, 64'(done_cnt[1] - d1), 64'd1);
    check("t3_overflow_sticky", 1, 64'(overflow[1]), 64'd1);

    // Byte in IDLE is ignored; gapped strobes pack correctly.
    send_byte(8'hFF);
    start_frame();
    check("t4_overflow_cleared", 1, 64'(overflow[1]), 64'd0);
    send_byte(8'hAA);
    repeat (2) @(negedge clk);
    send_byte(8'hBB);
    @(negedge clk);
    send_byte(8'hCC);
    repeat (3) @(negedge clk);
    send_byte(8'hDD);
    repeat (4) @(negedge clk);
    exp_q.push_back({12'h010, 32'hDDCCBBAA});
    check_log(0, "t4_write");
    exp_q.push_back({12'h010, 32'hDDCCBBAA});
    check_log(1, "t4_write");

    // Abort after 5 bytes; the coincident byte 0x99 must be discarded.
    start_frame();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    d0 = done_cnt[0];
    data_write = 1'b1;
    data_o     = 8'h99;
    start_frame();
    data_write = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
    repeat (6) @(negedge clk);
    exp_q.push_back({12'h010, 32'h14131211});
    exp_q.push_back({12'h011, 32'h18171615});
    check_log(0, "t5_write");
    check("t5_done_count", 0, 64'(done_cnt[0] - d0), 64'd1);

    // Asynchronous reset while both instances are draining.
    mem_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
    check("t6_valid_pre", 0, 64'(mem_valid[0]), 64'd1);
    check("t6_busy_pre", 1, 64'(busy[1]), 64'd1);
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    #2 rst = 1'b1;
    #1 check_reset_state("t6_async");
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_done_a", 0, 64'(done_cnt[0] - d0), 64'd0);
    check("t6_no_done_b", 1, 64'(done_cnt[1] - d1), 64'd0);
    check_log(0, "t6_write");

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      bit quiet;
      quiet = !(m_cap[0] | m_drn[0] | m_done[0] | m_cap[1] | m_drn[1] | m_done[1]);
      frame_start = quiet ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 249) == 0);
      data_write  = ($urandom_range(0, 9) < 7);
      data_o      = 8'($urandom_range(0, 255));
      if (stall == 0 && $urandom_range(0, 19) == 0) stall = $urandom_range(1, 12);
      if (stall > 0) begin
        mem_ready = 1'b0;
        stall--;
      end else begin
        mem_ready = ($urandom_range(0, 9) < 7);
      end
      @(negedge clk);
    end
    frame_start = 1'b0;
    data_write  = 1'b0;
    mem_ready   = 1'b1;
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_output_writer.md
Name: conv_output_writer

Overview:
- Downstream stage of the convolution filter top.
- Captures each output byte qualified by the filter's data_write strobe and packs four bytes into a 32-bit word.
- Buffers packed words in a small FIFO and writes them to frame memory over a valid/ready handshake with incrementing addresses.
- Flags end of frame and buffer overflow to the system controller.

Parameters:
- IMG_WIDTH, 64: output pixels per row.
- IMG_HEIGHT, 64: output rows per frame. IMG_WIDTH*IMG_HEIGHT must be a multiple of 4.
- ADDR_W, 12: word-address width.
- BASE_ADDR, 0: word address of the first frame word.
- FIFO_DEPTH, 4: packed-word FIFO entries, power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; arms capture of a new frame.
- data_write  in  1  byte-valid strobe from the filter.
- data_o  in  8  filter output byte; sampled only when data_write=1.
- mem_addr  out  ADDR_W  word address of the current write.
- mem_wdata  out  32  packed word.
- mem_valid  out  1  write request.
- mem_ready  in  1  memory accepts the write when mem_valid & mem_ready.
- frame_done  out  1  one-cycle pulse when the last word of the frame is accepted.
- overflow  out  1  sticky flag: a packed word was dropped.
- busy  out  1  high in CAPTURE and DRAIN.

Behaviour:
- Reset (async, any state): state=IDLE; byte/pixel counters, FIFO pointers and FIFO count =0; mem_addr=BASE_ADDR; mem_wdata=0; mem_valid=0; frame_done=0; overflow=0; busy=0.
- FSM states and transitions:
  - IDLE: data_write ignored. On frame_start -> CAPTURE; clear counters and overflow, set mem_addr=BASE_ADDR.
  - CAPTURE: each data_write=1 cycle stores data_o into byte lane (pix_cnt mod 4), little-endian (first byte in [7:0]), and increments pix_cnt. When the 4th byte of a word is stored, the full word is pushed into the FIFO on that same edge. When pix_cnt reaches IMG_WIDTH*IMG_HEIGHT -> DRAIN.
  - DRAIN: no capture; data_write ignored. When the FIFO is empty and no write is pending -> DONE.
  - DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- Output path:
  - mem_valid is registered and equals FIFO non-empty.
  - mem_wdata is the FIFO head; mem_addr is the address of the FIFO head.
  - First mem_valid rises one cycle after the push edge.
  - On mem_valid & mem_ready: pop the FIFO and increment mem_addr by 1 (wraps modulo 2^ADDR_W).
  - mem_valid, mem_wdata and mem_addr stay stable while mem_valid=1 and mem_ready=0.
- FIFO boundaries:
  - Simultaneous push and pop is legal at any fill level, including full; the count is unchanged.
  - Push while full with no pop in the same cycle: the word is dropped, overflow is set (sticky until the next frame_start), and pix_cnt still advances.
  - Addresses are assigned per pushed word, so a dropped word leaves an address hole; the following word takes the next address.
- frame_start during CAPTURE or DRAIN aborts the frame:
  - flush the FIFO, clear counters and overflow;
  - reset mem_addr to BASE_ADDR, deassert mem_valid the next cycle;
  - stay in CAPTURE (from CAPTURE) or go to CAPTURE (from DRAIN);
  - no frame_done for the aborted frame.
- frame_start coincident with data_write: frame_start wins and the byte is discarded.
- frame_done in DONE coincides with busy=0 in that cycle.
- Latency, last byte -> frame_done, with mem_ready held 1: last byte edge (push) -> mem_valid next cycle, accepted on that cycle -> FIFO empty -> DRAIN to DONE -> frame_done. Total 3 cycles after the last byte edge.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, BASE_ADDR=0x010, mem_ready=1; frame_start, then bytes 0x01..0x08 on consecutive cycles -> writes 0x04030201@0x010 and 0x08070605@0x011; one frame_done pulse 3 cycles after the last byte; overflow=0.
- Same frame with mem_ready=0 for 20 cycles after the first mem_valid -> mem_valid, mem_addr=0x010 and mem_wdata=0x04030201 held stable; both words are written once mem_ready=1; frame_done after the second accept.
- FIFO_DEPTH=2, 16-byte frame (4x4), mem_ready=0 throughout capture -> words 1-2 buffered, words 3-4 dropped, overflow=1. After releasing mem_ready: writes at 0x010 and 0x011 only, then frame_done; overflow stays 1 until the next frame_start.
- data_write pulses with gaps (bytes 0xAA, 0xBB, 0xCC, 0xDD spread over 10 cycles); data_write while IDLE with 0xFF -> 0xFF never captured; word 0xDDCCBBAA written.
- frame_start after 5 bytes of a frame, then 8 new bytes 0x11..0x18 -> no frame_done for the aborted frame; writes 0x14131211@0x010 and 0x18171615@0x011; one frame_done.
- rst asserted mid-DRAIN with mem_valid=1 -> all outputs zero, mem_addr=BASE_ADDR and state IDLE immediately (asynchronous); no frame_done after rst is released.
